// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store handshake with timeout, branch resolve, sticky error.
// Optional byte accesses are enabled by defining MEM_STAGE_BYTE_ACCESS_EN.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        zero,
    input  logic [31:0] branch_target,
    input  logic [4:0]  rd,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        branch,
    input  logic        reg_write,
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    input  logic        mem_byte,
    output logic [3:0]  mem_be,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  wait_cnt_r;
    logic        load_r;
    logic        reg_write_r;
    logic [4:0]  rd_r;

    logic        mem_op_s;
    logic        alu_op_s;
    logic        misalign_s;
    logic        take_s;
    logic        enter_s;
    logic        leave_s;
    logic        byte_s;
    logic [31:0] load_data_s;
    logic [31:0] wdata_s;
    logic        stall_s;
    logic        wb_valid_s;
    logic        wb_we_s;
    logic [4:0]  wb_rd_s;
    logic [31:0] wb_data_s;
    logic        err_set_s;

`ifdef MEM_STAGE_BYTE_ACCESS_EN
    logic        byte_r;
    logic [3:0]  be_s;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    assign byte_s      = mem_byte;
    assign load_data_s = byte_r ? {24'd0, lane_byte(mem_rdata, mem_addr[1:0])} : mem_rdata;
    assign wdata_s     = mem_byte ? {4{store_data[7:0]}} : store_data;
    assign be_s        = mem_byte ? (4'b0001 << alu_result[1:0]) : 4'b1111;
`else
    assign byte_s      = 1'b0;
    assign load_data_s = mem_rdata;
    assign wdata_s     = store_data;
`endif

    assign mem_op_s   = valid_in & (mem_read | mem_write);
    assign alu_op_s   = valid_in & ~mem_read & ~mem_write;
    assign misalign_s = ~byte_s & (alu_result[1:0] != 2'b00);
    assign take_s     = (state_r == IDLE) & valid_in & branch & zero;
    assign enter_s    = (state_r == IDLE) & (state_s == ACCESS);
    assign leave_s    = (state_r == ACCESS) & (state_s != ACCESS);
    assign stall      = stall_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ERROR is only left through reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    state_s = misalign_s ? ERROR : ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else if (wait_cnt_r == 4'd15) begin
                    state_s = ERROR;
                end else begin
                    state_s = ACCESS;
                end
            end
            ERROR:   state_s = ERROR;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: combinational stall and next values of the writeback/error registers
    always_comb begin
        stall_s    = 1'b0;
        wb_valid_s = 1'b0;
        wb_we_s    = 1'b0;
        wb_rd_s    = 5'd0;
        wb_data_s  = 32'd0;
        err_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s    = mem_op_s;
                err_set_s  = mem_op_s & misalign_s;
                wb_valid_s = alu_op_s;
                wb_we_s    = alu_op_s & reg_write;
                wb_rd_s    = alu_op_s ? rd : 5'd0;
                wb_data_s  = alu_op_s ? alu_result : 32'd0;
            end
            ACCESS: begin
                stall_s    = 1'b1;
                err_set_s  = ~mem_ack & (wait_cnt_r == 4'd15);
                wb_valid_s = mem_ack;
                wb_we_s    = mem_ack & reg_write_r & load_r;
                wb_rd_s    = mem_ack ? rd_r : 5'd0;
                wb_data_s  = mem_ack ? (load_r ? load_data_s : mem_addr) : 32'd0;
            end
            ERROR:   stall_s = 1'b1;
            default: stall_s = 1'b1;
        endcase
    end

    // Writeback, branch and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            pc_src    <= 1'b0;
            pc_target <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            wb_valid  <= wb_valid_s;
            wb_we     <= wb_we_s;
            wb_rd     <= wb_rd_s;
            wb_data   <= wb_data_s;
            pc_src    <= take_s;
            pc_target <= take_s ? branch_target : 32'd0;
            mem_err   <= mem_err | err_set_s;
        end
    end

    // Request latch; a simultaneous read+write is a store, so it never writes back read data
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            load_r      <= 1'b0;
            reg_write_r <= 1'b0;
            rd_r        <= 5'd0;
        end else if (enter_s) begin
            mem_req     <= 1'b1;
            mem_we      <= mem_write;
            mem_addr    <= alu_result;
            mem_wdata   <= wdata_s;
            load_r      <= mem_read & ~mem_write;
            reg_write_r <= reg_write;
            rd_r        <= rd;
        end else if (leave_s) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    // Wait counter: cleared on entry, counts ACCESS cycles without ack
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (enter_s) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ACCESS) && !mem_ack) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end

`ifdef MEM_STAGE_BYTE_ACCESS_EN
    // Byte-enable and byte-load tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_be <= 4'd0;
            byte_r <= 1'b0;
        end else if (enter_s) begin
            mem_be <= be_s;
            byte_r <= mem_byte;
        end else if (leave_s) begin
            mem_be <= 4'd0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks, a monitor pops on wb_valid.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        zero;
    logic [31:0] branch_target;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_err;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    logic        mem_byte;
    logic [3:0]  mem_be;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
        .store_data(store_data), .zero(zero), .branch_target(branch_target), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .reg_write(reg_write),
`ifdef MEM_STAGE_BYTE_ACCESS_EN
        .mem_byte(mem_byte), .mem_be(mem_be),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pc_src(pc_src),
        .pc_target(pc_target), .mem_err(mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        reg_write = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic we, input logic [31:0] d);
        wb_t e;
        e.rd   = r;
        e.we   = we;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_wb"}, {wb_valid, wb_we, wb_rd, 25'd0}, 32'd0);
        chk({nm, "_wb_data"}, wb_data, 32'd0);
        chk({nm, "_pc_src"}, {31'd0, pc_src}, 32'd0);
        chk({nm, "_pc_target"}, pc_target, 32'd0);
        chk({nm, "_mem_err"}, {31'd0, mem_err}, 32'd0);
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] r, input logic rw,
                          input logic [4:0] exp_rd, input logic exp_we, input logic [31:0] exp_d);
        valid_in   = 1'b1;
        alu_result = res;
        rd         = r;
        reg_write  = rw;
        push_exp(exp_rd, exp_we, exp_d);
        #1;
        chk("alu_stall", {31'd0, stall}, 32'd0);
        cyc();
        idle_in();
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        cyc();
        chk("alu_wb_pulse", {31'd0, wb_valid}, 32'd0);
    endtask

    // Memory op acked in the ack_at-th ACCESS cycle; caller gives expected bus and writeback values
    task automatic mem_op(input string nm, input logic rdf, input logic wrf,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r,
                          input logic rw, input int ack_at, input logic [31:0] rdata,
                          input logic exp_mwe, input logic [31:0] exp_wd,
                          input logic exp_we, input logic [31:0] exp_d);
        int stalls;
        stalls     = 0;
        valid_in   = 1'b1;
        mem_read   = rdf;
        mem_write  = wrf;
        alu_result = addr;
        store_data = sd;
        rd         = r;
        reg_write  = rw;
        push_exp(r, exp_we, exp_d);
        #1;
        if (stall === 1'b1) stalls++;
        cyc();
        idle_in();
        alu_result = 32'hBAD0_0000;
        store_data = 32'hBAD1_1111;
        rd         = 5'd0;
        for (int i = 1; i <= ack_at; i++) begin
            if (i == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            if (stall === 1'b1) stalls++;
            chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
            chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, exp_mwe});
            chk({nm, "_addr"}, mem_addr, addr);
            if (wrf) chk({nm, "_wdata"}, mem_wdata, exp_wd);
            cyc();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        chk({nm, "_stalls"}, stalls, ack_at + 1);
        chk({nm, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        chk({nm, "_err"}, {31'd0, mem_err}, 32'd0);
    endtask

    // Monitor: every wb_valid pulse must match the oldest expected writeback
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        idle_in();
        reset         = 1'b1;
        alu_result    = 32'd0;
        store_data    = 32'd0;
        branch_target = 32'd0;
        rd            = 5'd0;
        mem_rdata     = 32'd0;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
        mem_byte      = 1'b0;
`endif
        cyc();
        cyc();
        chk_zero("reset");
        reset = 1'b0;
        cyc();

        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("stray_ack_stall", {31'd0, stall}, 32'd0);
        cyc();

        alu_op(32'h0000_002A, 5'd5, 1'b1, 5'd5, 1'b1, 32'h0000_002A);
        alu_op(32'hFFFF_FFFF, 5'd31, 1'b0, 5'd31, 1'b0, 32'hFFFF_FFFF);

        valid_in      = 1'b1;
        branch        = 1'b1;
        zero          = 1'b1;
        branch_target = 32'h0000_0040;
        alu_result    = 32'h0000_0010;
        rd            = 5'd0;
        push_exp(5'd0, 1'b0, 32'h0000_0010);
        #1;
        chk("br_stall", {31'd0, stall}, 32'd0);
        cyc();
        idle_in();
        chk("br_pc_src", {31'd0, pc_src}, 32'd1);
        chk("br_pc_target", pc_target, 32'h0000_0040);
        cyc();
        chk("br_pc_src_pulse", {31'd0, pc_src}, 32'd0);
        chk("br_pc_target_clr", pc_target, 32'd0);

        valid_in      = 1'b1;
        branch        = 1'b1;
        zero          = 1'b0;
        branch_target = 32'h0000_0080;
        alu_result    = 32'h0000_0014;
        push_exp(5'd0, 1'b0, 32'h0000_0014);
        cyc();
        idle_in();
        chk("nbr_pc_src", {31'd0, pc_src}, 32'd0);
        cyc();

        mem_op("load", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF,
               1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        mem_op("store", 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 5'd3, 1'b0, 3, 32'h5555_5555,
               1'b1, 32'h1234_5678, 1'b0, 32'h0000_0104);
        mem_op("rdwr", 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd4, 1'b1, 1, 32'h1111_1111,
               1'b1, 32'hCAFE_F00D, 1'b0, 32'h0000_0200);
        mem_op("ack16", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 16, 32'hA5A5_A5A5,
               1'b0, 32'h0, 1'b1, 32'hA5A5_A5A5);

        valid_in   = 1'b1;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0400;
        rd         = 5'd10;
        reg_write  = 1'b1;
        cyc();
        idle_in();
        for (int i = 1; i <= 16; i++) begin
            chk("tmo_req", {31'd0, mem_req}, 32'd1);
            chk("tmo_err_early", {31'd0, mem_err}, 32'd0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk("tmo_err", {31'd0, mem_err}, 32'd1);
            chk("tmo_stall", {31'd0, stall}, 32'd1);
            chk("tmo_req_off", {31'd0, mem_req}, 32'd0);
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
        end
        reset = 1'b1;
        cyc();
        chk_zero("tmo_reset");
        reset = 1'b0;
        cyc();

        valid_in   = 1'b1;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0500;
        rd         = 5'd11;
        reg_write  = 1'b1;
        cyc();
        idle_in();
        chk("rst_acc_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst_acc_req_drop", {31'd0, mem_req}, 32'd0);
        reset   = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        cyc();
        mem_ack = 1'b0;
        chk("rst_acc_stall", {31'd0, stall}, 32'd0);
        cyc();

        valid_in   = 1'b1;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0102;
        rd         = 5'd12;
        reg_write  = 1'b1;
        #1;
        chk("mis_stall_issue", {31'd0, stall}, 32'd1);
        cyc();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk("mis_req", {31'd0, mem_req}, 32'd0);
            chk("mis_err", {31'd0, mem_err}, 32'd1);
            chk("mis_stall", {31'd0, stall}, 32'd1);
            cyc();
        end
        reset = 1'b1;
        cyc();
        chk_zero("mis_reset");
        reset = 1'b0;
        cyc();

        alu_op(32'h0000_0077, 5'd12, 1'b1, 5'd12, 1'b1, 32'h0000_0077);

        cyc();
        cyc();
        chk("wb_missing", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
